// File: rtl/list_arbiter.sv
// Round-robin arbiter granting four consumers exclusive access to one upstream
// list source; a grant is held from the first element until end-of-list.
module list_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ready,
    input  logic [3:0]       c_req,
    output logic [3:0]       c_ack,
    output logic [WIDTH-1:0] c_value,
    output logic             c_value_valid,
    output logic             up_req,
    input  logic             up_ack,
    input  logic [WIDTH-1:0] up_value,
    input  logic             up_value_valid,
    output logic [3:0]       grant,
    output logic             busy,
    output logic [7:0]       elem_count,
    output logic             list_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic       r_busy;
    logic [7:0] r_elem_count;
    logic       r_list_done;

    logic [1:0] w_win_idx;
    logic       w_win_found;
    logic [3:0] w_win_onehot;
    logic [1:0] w_grant_idx;
    logic       w_elem_hs;
    logic       w_end_hs;

    // Search starts one past the last owner, so the last owner wins only alone.
    always_comb begin
        w_win_idx   = r_ptr;
        w_win_found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!w_win_found && c_req[r_ptr + 2'(i)]) begin
                w_win_idx   = r_ptr + 2'(i);
                w_win_found = 1'b1;
            end
        end
    end

    assign w_win_onehot = 4'b0001 << w_win_idx;

    always_comb begin
        w_grant_idx = 2'd0;
        case (r_grant)
            4'b0010: w_grant_idx = 2'd1;
            4'b0100: w_grant_idx = 2'd2;
            4'b1000: w_grant_idx = 2'd3;
            default: w_grant_idx = 2'd0;
        endcase
    end

    assign w_elem_hs = (r_state == BUSY) && up_ack && up_value_valid;
    assign w_end_hs  = (r_state == BUSY) && up_ack && !up_value_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ptr        <= 2'd3;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_elem_count <= '0;
            r_list_done  <= 1'b0;
        end else if (!ready) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd3;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_list_done <= 1'b0;
        end else begin
            r_list_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state      <= BUSY;
                        r_grant      <= w_win_onehot;
                        r_busy       <= 1'b1;
                        r_elem_count <= '0;
                    end
                end
                BUSY: begin
                    if (w_elem_hs && (r_elem_count != 8'hFF)) begin
                        r_elem_count <= r_elem_count + 8'd1;
                    end
                    if (w_end_hs) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_ptr       <= w_grant_idx;
                        r_list_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign up_req        = (r_state == BUSY) && c_req[w_grant_idx];
    assign c_ack         = ((r_state == BUSY) && up_ack) ? r_grant : '0;
    assign c_value       = up_value;
    assign c_value_valid = up_value_valid;

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign elem_count = r_elem_count;
    assign list_done  = r_list_done;

endmodule

// File: tb/tb_list_arbiter.sv
// Directed bench for list_arbiter: arbitration order, grant hold, counting,
// ready abort and asynchronous reset, all against hand-computed values.
module tb_list_arbiter;

    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             ready;
    logic [3:0]       c_req;
    logic [3:0]       c_ack;
    logic [WIDTH-1:0] c_value;
    logic             c_value_valid;
    logic             up_req;
    logic             up_ack;
    logic [WIDTH-1:0] up_value;
    logic             up_value_valid;
    logic [3:0]       grant;
    logic             busy;
    logic [7:0]       elem_count;
    logic             list_done;

    int n_vec = 0;
    int n_err = 0;

    list_arbiter #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ready          (ready),
        .c_req          (c_req),
        .c_ack          (c_ack),
        .c_value        (c_value),
        .c_value_valid  (c_value_valid),
        .up_req         (up_req),
        .up_ack         (up_ack),
        .up_value       (up_value),
        .up_value_valid (up_value_valid),
        .grant          (grant),
        .busy           (busy),
        .elem_count     (elem_count),
        .list_done      (list_done)
    );

    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ready          = 1'b1;
        c_req          = 4'b1111;
        up_ack         = 1'b1;
        up_value       = 8'h3C;
        up_value_valid = 1'b1;
        tick();
        tick();
        n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want %b", grant, 4'b0000); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (elem_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", elem_count); end
        n_vec++; if (list_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", list_done); end
        n_vec++; if (up_req !== 1'b0) begin n_err++; $display("FAIL reset_up_req got %b want 0", up_req); end
        n_vec++; if (c_ack !== 4'b0000) begin n_err++; $display("FAIL reset_c_ack got %b want 0000", c_ack); end
        n_vec++; if (c_value !== 8'h3C) begin n_err++; $display("FAIL reset_c_value got %h want 3c", c_value); end
        up_ack = 1'b0;
        c_req  = 4'b0000;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_list();
        c_req = 4'b0101;
        tick();
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL basic_grant0 got %b want 0001", grant); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
        n_vec++; if (up_req !== 1'b1) begin n_err++; $display("FAIL basic_up_req got %b want 1", up_req); end
        up_ack = 1'b1; up_value_valid = 1'b1; up_value = 8'hA5;
        #1;
        n_vec++; if (c_ack !== 4'b0001) begin n_err++; $display("FAIL basic_c_ack got %b want 0001", c_ack); end
        n_vec++; if (c_value !== 8'hA5 || c_value_valid !== 1'b1) begin n_err++; $display("FAIL basic_c_value got %h/%b want a5/1", c_value, c_value_valid); end
        tick(); tick(); tick();
        n_vec++; if (elem_count !== 8'd3) begin n_err++; $display("FAIL basic_count got %0d want 3", elem_count); end
        n_vec++; if (list_done !== 1'b0) begin n_err++; $display("FAIL basic_done_early got %b want 0", list_done); end
        up_value_valid = 1'b0;
        #1;
        n_vec++; if (c_ack !== 4'b0001 || c_value_valid !== 1'b0) begin n_err++; $display("FAIL basic_eol_ack got %b/%b want 0001/0", c_ack, c_value_valid); end
        tick();
        up_ack = 1'b0;
        n_vec++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL basic_eol_idle got %b/%b want 0000/0", grant, busy); end
        n_vec++; if (list_done !== 1'b1) begin n_err++; $display("FAIL basic_done got %b want 1", list_done); end
        n_vec++; if (elem_count !== 8'd3) begin n_err++; $display("FAIL basic_count_hold got %0d want 3", elem_count); end
        n_vec++; if (up_req !== 1'b0 || c_ack !== 4'b0000) begin n_err++; $display("FAIL basic_idle_out got %b/%b want 0/0000", up_req, c_ack); end
        tick();
        n_vec++; if (list_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", list_done); end
        n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL basic_grant2 got %b want 0100", grant); end
        n_vec++; if (elem_count !== 8'd0) begin n_err++; $display("FAIL basic_count_clear got %0d want 0", elem_count); end
        up_ack = 1'b1; up_value_valid = 1'b0;
        tick();
        up_ack = 1'b0;
        c_req = 4'b0000;
        n_vec++; if (grant !== 4'b0000 || list_done !== 1'b1) begin n_err++; $display("FAIL basic_eol2 got %b/%b want 0000/1", grant, list_done); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_grant [4];
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010;
        exp_grant[2] = 4'b0100; exp_grant[3] = 4'b1000;
        ready = 1'b0;
        tick();
        ready = 1'b1;
        c_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (grant !== exp_grant[i]) begin n_err++; $display("FAIL rr_grant%0d got %b want %b", i, grant, exp_grant[i]); end
            up_ack = 1'b1; up_value_valid = 1'b0;
            tick();
            up_ack = 1'b0;
            n_vec++; if (grant !== 4'b0000 || list_done !== 1'b1) begin n_err++; $display("FAIL rr_idle%0d got %b/%b want 0000/1", i, grant, list_done); end
        end
        c_req = 4'b0000;
        tick();
    endtask

    task automatic test_hold();
        c_req = 4'b0010;
        tick();
        n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL hold_grant got %b want 0010", grant); end
        c_req = 4'b0100;
        #1;
        n_vec++; if (up_req !== 1'b0) begin n_err++; $display("FAIL hold_up_req_drop got %b want 0", up_req); end
        tick();
        n_vec++; if (grant !== 4'b0010 || busy !== 1'b1) begin n_err++; $display("FAIL hold_no_preempt got %b/%b want 0010/1", grant, busy); end
        up_ack = 1'b1; up_value_valid = 1'b1; up_value = 8'h11;
        #1;
        n_vec++; if (c_ack !== 4'b0010) begin n_err++; $display("FAIL hold_c_ack got %b want 0010", c_ack); end
        tick();
        n_vec++; if (grant !== 4'b0010 || elem_count !== 8'd1) begin n_err++; $display("FAIL hold_count got %b/%0d want 0010/1", grant, elem_count); end
        up_value_valid = 1'b0;
        tick();
        up_ack = 1'b0;
        n_vec++; if (grant !== 4'b0000 || list_done !== 1'b1) begin n_err++; $display("FAIL hold_eol got %b/%b want 0000/1", grant, list_done); end
        tick();
        n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL hold_next got %b want 0100", grant); end
        // ptr becomes 2; consumer 2 re-requesting alongside consumer 0 must lose
        c_req = 4'b0101;
        up_ack = 1'b1; up_value_valid = 1'b0;
        tick();
        up_ack = 1'b0;
        tick();
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rereq_lose got %b want 0001", grant); end
        c_req = 4'b0001;
        up_ack = 1'b1;
        tick();
        up_ack = 1'b0;
        tick();
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rereq_sole got %b want 0001", grant); end
    endtask

    task automatic test_saturate();
        // consumer 0 already owns the source from the previous scenario
        up_ack = 1'b1; up_value_valid = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        n_vec++; if (elem_count !== 8'd254) begin n_err++; $display("FAIL sat_254 got %0d want 254", elem_count); end
        for (int i = 0; i < 46; i++) tick();
        n_vec++; if (elem_count !== 8'd255) begin n_err++; $display("FAIL sat_300 got %0d want 255", elem_count); end
        c_req = 4'b0000;
        up_value_valid = 1'b0;
        tick();
        up_ack = 1'b0;
        n_vec++; if (list_done !== 1'b1 || elem_count !== 8'd255) begin n_err++; $display("FAIL sat_eol got %b/%0d want 1/255", list_done, elem_count); end
        tick();
        n_vec++; if (elem_count !== 8'd255 || grant !== 4'b0000) begin n_err++; $display("FAIL sat_hold got %0d/%b want 255/0000", elem_count, grant); end
    endtask

    task automatic test_ready_abort();
        c_req = 4'b0010;
        tick();
        n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL abort_grant got %b want 0010", grant); end
        up_ack = 1'b1; up_value_valid = 1'b1;
        tick();
        up_value_valid = 1'b0;
        ready = 1'b0;
        tick();
        n_vec++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b/%b want 0000/0", grant, busy); end
        n_vec++; if (list_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b want 0", list_done); end
        n_vec++; if (elem_count !== 8'd1) begin n_err++; $display("FAIL abort_count got %0d want 1", elem_count); end
        n_vec++; if (up_req !== 1'b0 || c_ack !== 4'b0000) begin n_err++; $display("FAIL abort_out got %b/%b want 0/0000", up_req, c_ack); end
        up_ack = 1'b0;
        c_req = 4'b1001;
        tick();
        n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL abort_held got %b want 0000", grant); end
        ready = 1'b1;
        tick();
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL abort_regrant got %b want 0001", grant); end
    endtask

    task automatic test_async_reset();
        up_ack = 1'b1; up_value_valid = 1'b1;
        #1;
        n_vec++; if (up_req !== 1'b1 || c_ack !== 4'b0001) begin n_err++; $display("FAIL areset_pre got %b/%b want 1/0001", up_req, c_ack); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL areset_state got %b/%b want 0000/0", grant, busy); end
        n_vec++; if (up_req !== 1'b0 || c_ack !== 4'b0000) begin n_err++; $display("FAIL areset_out got %b/%b want 0/0000", up_req, c_ack); end
        n_vec++; if (elem_count !== 8'd0 || list_done !== 1'b0) begin n_err++; $display("FAIL areset_regs got %0d/%b want 0/0", elem_count, list_done); end
        up_ack = 1'b0;
        ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_vec++; if (grant !== 4'b0000 || list_done !== 1'b0) begin n_err++; $display("FAIL areset_wait got %b/%b want 0000/0", grant, list_done); end
        ready = 1'b1;
        tick();
        n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL areset_first got %b want 0001", grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_list();
        test_round_robin();
        test_hold();
        test_saturate();
        test_ready_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/list_arbiter.md
LIST_ARBITER -- requirements
Module: list_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, list element width in bits.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 ready  in  1  synchronous enable; low aborts any grant and forces IDLE.
REQ-005 c_req  in  4  per-consumer list element request, bit i = consumer i.
REQ-006 c_ack  out  4  per-consumer acknowledge, at most one bit set.
REQ-007 c_value  out  WIDTH  element value, broadcast to all consumers.
REQ-008 c_value_valid  out  1  element valid, broadcast; with c_ack[i] high and this low, the list has ended for consumer i.
REQ-009 up_req  out  1  request to the shared upstream list source.
REQ-010 up_ack  in  1  upstream acknowledge.
REQ-011 up_value  in  WIDTH  upstream element value.
REQ-012 up_value_valid  in  1  upstream element valid; up_ack high with this low marks end-of-list.
REQ-013 grant  out  4  registered one-hot owner of the upstream source; 0 when idle.
REQ-014 busy  out  1  registered; high while in BUSY.
REQ-015 elem_count  out  8  registered count of valid elements delivered in the current or last list.
REQ-016 list_done  out  1  registered one-cycle pulse after an end-of-list handshake.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and BUSY; grant, busy, elem_count and list_done SHALL be registers.
REQ-018 IDLE: with ready high and c_req nonzero, the arbiter SHALL choose the winner round-robin, searching upward from (ptr+1) mod 4 and wrapping.
REQ-019 On the next edge after that choice it SHALL load the winner's one-hot into grant, set busy, clear elem_count and enter BUSY. Arbitration latency is 1 cycle.
REQ-020 In IDLE the outputs SHALL be: up_req=0, c_ack=0. Upstream handshakes arriving in IDLE SHALL be ignored.
REQ-021 In BUSY with grant bit g, the datapath SHALL be combinational: up_req=c_req[g]; c_ack[g]=up_ack; all other c_ack bits 0.
REQ-022 c_value SHALL follow up_value and c_value_valid SHALL follow up_value_valid in every state.
REQ-023 A grant SHALL be held until end-of-list, even if c_req[g] drops; other consumers' requests SHALL NOT preempt it.
REQ-024 An element handshake is up_ack=1 and up_value_valid=1 in BUSY. On each one, elem_count SHALL increment, saturating at 255.
REQ-025 End-of-list is up_ack=1 and up_value_valid=0 in BUSY. On that edge the block SHALL:
  - enter IDLE and clear grant and busy;
  - set ptr to g;
  - pulse list_done for exactly one cycle;
  - hold elem_count.
REQ-026 IDLE SHALL last at least one cycle between grants, so back-to-back lists occupy BUSY, IDLE, BUSY.
REQ-027 If consumer g re-requests at end-of-list, it SHALL lose to any other requester. It SHALL win only when it is the sole requester.
REQ-028 ready low at any edge SHALL force IDLE, clear grant, busy and list_done, set ptr=3 and hold elem_count. This takes priority over every other transition.
REQ-029 While ready is low, up_req and c_ack SHALL evaluate through the IDLE path, so both are 0 from the edge at which ready is sampled low.

Reset
REQ-030 reset_n low SHALL immediately, without waiting for a clock edge, force:
  - state=IDLE, ptr=3;
  - grant=0, busy=0, elem_count=0, list_done=0;
  - through the IDLE path, up_req=0 and c_ack=0.
REQ-031 After reset_n rises, the first grant SHALL be taken no earlier than the first clock edge at which ready=1 and c_req is nonzero.
REQ-032 An assertion of reset_n in mid-list SHALL abandon the list; no list_done pulse SHALL be produced.

Verification
REQ-033 Reset, ready=1, c_req=4'b0101 -> grant=4'b0001 on the next edge. Then 3 valid handshakes plus end-of-list -> elem_count=3, list_done pulses once, then grant=4'b0100.
REQ-034 c_req=4'b1111 held across four full lists -> grants in order 0001, 0010, 0100, 1000, each separated by one IDLE cycle.
REQ-035 Consumer 1 granted and drops c_req mid-list while consumer 2 requests -> grant stays 4'b0010 until end-of-list; up_req=0 while c_req[1]=0.
REQ-036 300 valid handshakes in one list -> elem_count saturates at 255 and holds 255 after list_done.
REQ-037 ready driven low mid-list -> next edge grant=0, busy=0, no list_done. After ready returns with c_req=4'b1001 -> grant=4'b0001.
REQ-038 reset_n asserted between edges in BUSY -> grant, busy, up_req and c_ack go to 0 before the next clock edge.
